// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side burst master for an 8-deep FIFO.
// It only requests a word that is known to be present and that has a free
// slot waiting for it. Returned words pass through a 2-entry skid buffer
// onto a valid/ready stream. The final beat of each burst is tagged.
`default_nettype none

module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    input  logic [CNT_WIDTH-1:0]  fifo_data_count,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERROR} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  issue_cnt;   // reads still to request
    logic [CNT_WIDTH-1:0]  rem_cnt;     // beats still to hand over
    logic                  inflight;    // one read awaiting its ack
    logic [1:0]            buf_occ;     // skid buffer occupancy, 0..2
    logic [DATA_WIDTH-1:0] buf0;        // head entry (drives m_data)
    logic [DATA_WIDTH-1:0] buf1;        // second entry

    logic [CNT_WIDTH-1:0]  cnt_sat;
    logic [2:0]            pending;
    logic                  capture;
    logic                  timeout;
    logic                  err_evt;
    logic                  pop;

    // An occupancy above the FIFO capacity can only be a glitch on the
    // input. Clamping it keeps one bad value from causing extra reads.
    assign cnt_sat = (fifo_data_count > CNT_WIDTH'(FIFO_DEPTH)) ?
                     CNT_WIDTH'(FIFO_DEPTH) : fifo_data_count;

    // Words that already have a skid slot claimed: buffered plus outstanding.
    assign pending = {1'b0, buf_occ} + {2'b00, inflight};

    assign capture = inflight & fifo_rd_ack;
    assign timeout = inflight & ~fifo_rd_ack;
    assign err_evt = fifo_rd_err | timeout;
    assign pop     = m_valid & m_ready;

    // A request also needs a word the FIFO still holds that no earlier
    // read has claimed. It is withheld while an error is being flagged,
    // so the FIFO does not lose a word the flush would throw away.
    assign fifo_rd_en = (state == ISSUE) && (issue_cnt != '0)
                        && (cnt_sat > {{(CNT_WIDTH-1){1'b0}}, inflight})
                        && (pending < 3'd2)
                        && !err_evt;

    assign m_valid = (buf_occ != 2'd0);
    assign m_data  = buf0;
    assign m_last  = m_valid && (rem_cnt == CNT_WIDTH'(1));

    // Burst sequencing: IDLE -> ISSUE -> DRAIN -> IDLE, with ERROR from anywhere.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            issue_cnt <= '0;
            rem_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (err_evt) begin
                // A new error also wins over an err_clr in the same cycle.
                state <= ERROR;
                busy  <= 1'b1;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (burst_len != '0) begin
                                state     <= ISSUE;
                                busy      <= 1'b1;
                                issue_cnt <= burst_len;
                                rem_cnt   <= burst_len;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (fifo_rd_en) begin
                            issue_cnt <= issue_cnt - 1'b1;
                            if (issue_cnt == CNT_WIDTH'(1))
                                state <= DRAIN;
                        end
                        if (pop)
                            rem_cnt <= rem_cnt - 1'b1;
                    end
                    DRAIN: begin
                        if (pop) begin
                            rem_cnt <= rem_cnt - 1'b1;
                            if (m_last) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ERROR: begin
                        if (err_clr) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Outstanding-read flag. A new request may replace an ack that arrives in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            inflight <= 1'b0;
        else if (err_evt)
            inflight <= 1'b0;
        else if (fifo_rd_en)
            inflight <= 1'b1;
        else if (fifo_rd_ack)
            inflight <= 1'b0;
    end

    // Two-entry skid buffer in FIFO order. Capture and pop in one cycle keep the occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_occ <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else if (err_evt || state == ERROR) begin
            buf_occ <= 2'd0;
        end else begin
            case ({capture, pop})
                2'b10: begin
                    if (buf_occ == 2'd0) begin
                        buf0    <= fifo_dout;
                        buf_occ <= 2'd1;
                    end else if (buf_occ == 2'd1) begin
                        buf1    <= fifo_dout;
                        buf_occ <= 2'd2;
                    end
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_occ <= buf_occ - 2'd1;
                end
                2'b11: begin
                    if (buf_occ == 2'd1) begin
                        buf0 <= fifo_dout;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl. It contains a behavioural FIFO model and a log of
// every word written. Each stream beat is checked against the written words
// in order. Burst length, last flag, done and busy are checked against the
// burst rules.
`timescale 1ns/1ps

module tb_fifo_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  burst_len;
    logic [3:0]  fifo_data_count = 4'd0;
    logic        fifo_rd_ack = 1'b0;
    logic        fifo_rd_err = 1'b0;
    logic [31:0] fifo_dout = 32'd0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;
    logic        err_clr;

    fifo_rd_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
        .fifo_data_count(fifo_data_count), .fifo_rd_ack(fifo_rd_ack),
        .fifo_rd_err(fifo_rd_err), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // stimulus controls (written only by the initial block)
    int ready_mode = 1;      // 0 low, 1 high, 2 random
    int writer_mode = 0;     // 0 off, 1 every 10 cycles, 2 random
    int fill_req = 0;
    int err_at_rd = -1;

    // FIFO model state
    logic [31:0] fq[$];
    logic [31:0] wlog[$];
    int          rd_total = 0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'd0;
    int          fill_done = 0;

    // monitor state
    int          cyc = 0;
    int          rd_ptr = 0;
    int          cur_len = 0;
    int          beat_cnt = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          rd_err_seen = 0;
    int          first_rd = -1;
    int          first_vld = -1;
    logic        tb_busy = 1'b0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_d = 32'd0;
    logic        hold_l = 1'b0;

    // Behavioural FIFO: one-cycle read response, registered occupancy.
    always @(posedge clk) begin
        fifo_rd_ack <= 1'b0;
        fifo_rd_err <= 1'b0;
        if (fifo_rd_en) begin
            if (rd_total == err_at_rd || fq.size() == 0) begin
                fifo_rd_err <= 1'b1;
            end else begin
                fifo_dout   <= fq.pop_front();
                fifo_rd_ack <= 1'b1;
            end
            rd_total <= rd_total + 1;
        end
        if (wr_en) begin
            fq.push_back(wr_data);
            wlog.push_back(wr_data);
        end
        fifo_data_count <= 4'(fq.size());
    end

    // Sink readiness and FIFO writer, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        wr_en   = 1'b0;
        wr_data = $urandom;
        if (fq.size() < 8) begin
            if (fill_done < fill_req) begin
                wr_en = 1'b1;
                fill_done++;
            end else if (writer_mode == 1 && (cyc % 10) == 0) begin
                wr_en = 1'b1;
            end else if (writer_mode == 2 && $urandom_range(0, 1) == 1) begin
                wr_en = 1'b1;
            end
        end
    end

    // Reference checks, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] exp_d;
        cyc++;
        if (!reset_n) begin
            hold_v  = 1'b0;
            tb_busy = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                tb_busy = 1'b0;
                chk("done_beats", beat_cnt, cur_len);
                chk("done_reads", rd_cnt, cur_len);
            end
            chk("busy", 32'(busy), 32'(tb_busy));
            if (!tb_busy)
                rd_ptr = wlog.size() - fq.size();
            if (fifo_rd_err)
                rd_err_seen++;
            if (fifo_rd_en) begin
                chk("rd_nonempty", 32'(fifo_data_count != 4'd0), 32'd1);
                chk("rd_window", 32'((rd_cnt - beat_cnt) <= 1), 32'd1);
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (hold_v && !err) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", m_data, hold_d);
                chk("hold_last", 32'(m_last), 32'(hold_l));
            end
            if (m_valid && m_ready) begin
                exp_d = (rd_ptr < wlog.size()) ? wlog[rd_ptr] : ~m_data;
                chk("beat_data", m_data, exp_d);
                chk("beat_last", 32'(m_last), 32'(beat_cnt + 1 == cur_len));
                rd_ptr++;
                beat_cnt++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (err_clr)
                tb_busy = 1'b0;
            if (start && !tb_busy) begin
                cur_len   = int'(burst_len);
                tb_busy   = (burst_len != 4'd0);
                beat_cnt  = 0;
                rd_cnt    = 0;
                first_rd  = -1;
                first_vld = -1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        burst_len = 4'(len);
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int max, input string tag);
        int d0 = done_cnt;
        for (int i = 0; i < max; i++) begin
            tick(1);
            if (done_cnt > d0) break;
        end
        chk(tag, 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic fill_to(input int n);
        fill_req += n - int'(fifo_data_count);
        for (int i = 0; i < 30; i++) begin
            if (int'(fifo_data_count) == n) break;
            tick(1);
        end
        chk("fill", 32'(fifo_data_count), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int ok;
        reset_n = 1'b0; start = 1'b0; burst_len = 4'd0; err_clr = 1'b0;
        tick(3);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // basic burst of 4 from a full FIFO
        ready_mode = 1;
        fill_to(8);
        tick(1);
        do_start(4);
        chk("basic_busy", 32'(busy), 32'd1);
        wait_done(60, "basic_done");
        chk("basic_latency", first_vld - first_rd, 32'd2);
        tick(2);
        chk("basic_count", 32'(fifo_data_count), 32'd4);

        // drain the rest with a random sink
        ready_mode = 2;
        do_start(4);
        wait_done(100, "drain_done");
        tick(2);
        chk("drain_empty", 32'(fifo_data_count), 32'd0);

        // starved FIFO: one word every 10 cycles
        e0 = rd_err_seen;
        ready_mode = 1;
        writer_mode = 1;
        do_start(3);
        wait_done(200, "starve_done");
        writer_mode = 0;
        chk("starve_no_err", rd_err_seen - e0, 32'd0);
        tick(3);

        // backpressure: reads stop with both skid slots claimed
        fill_to(8);
        tick(1);
        ready_mode = 0;
        do_start(8);
        tick(20);
        chk("bp_reads", rd_cnt, 32'd2);
        chk("bp_valid", 32'(m_valid), 32'd1);
        ready_mode = 1;
        wait_done(100, "bp_done");

        // forced read error on the second read
        fill_to(8);
        tick(1);
        e0 = rd_err_seen;
        err_at_rd = rd_total + 1;
        do_start(6);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (err) begin ok = 1; break; end
        end
        chk("err_set", ok, 32'd1);
        tick(2);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_m_valid", 32'(m_valid), 32'd0);
        chk("err_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("err_seen", rd_err_seen - e0, 32'd1);
        err_at_rd = -1;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        tick(1);
        do_start(3);
        wait_done(60, "post_err_done");

        // zero-length burst: done next cycle, no reads
        tick(2);
        start = 1'b1; burst_len = 4'd0;
        tick(1);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        tick(3);
        chk("len0_reads", rd_cnt, 32'd0);

        // start while busy is ignored
        fill_to(8);
        tick(1);
        do_start(4);
        tick(2);
        do_start(2);
        wait_done(80, "busy_start_done");
        chk("busy_start_len", beat_cnt, 32'd4);

        // 15-word burst with a refilling writer and random sink
        writer_mode = 2;
        ready_mode = 2;
        do_start(15);
        wait_done(600, "len15_done");
        chk("len15_beats", beat_cnt, 32'd15);

        // randomized bursts
        for (int r = 0; r < 8; r++) begin
            do_start($urandom_range(1, 15));
            wait_done(600, "rand_done");
            tick($urandom_range(0, 4));
        end
        writer_mode = 0;
        chk("no_rd_err_total", rd_err_seen, 32'd1);

        // reset mid-burst with a word buffered
        writer_mode = 2;
        ready_mode = 0;
        do_start(4);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            if (m_valid) begin ok = 1; break; end
            tick(1);
        end
        chk("rst_pre_valid", ok, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstm_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rstm_m_valid", 32'(m_valid), 32'd0);
        chk("rstm_m_data", m_data, 32'd0);
        chk("rstm_m_last", 32'(m_last), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_done", 32'(done), 32'd0);
        chk("rstm_err", 32'(err), 32'd0);
        writer_mode = 0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
